// File: rtl/led7seg_pkg.sv
// Shared types and constants for the 74HC595-driven 7-segment scan logic.
package led7seg_pkg;

    localparam int SEG_W      = 8;
    localparam int WORD_W     = 16;
    localparam int MAX_DIGITS = 8;

    // Serial engine states; HOLD belongs to the scan scheduler's view of a slot.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        HOLD
    } scan_state_t;

    // Scheduler phase: waiting for enable, transaction in flight, or holding a digit.
    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_XFER,
        SCAN_HOLD
    } scan_phase_t;

    // One-hot, active-high digit select byte.
    function automatic logic [SEG_W-1:0] digit_sel(input logic [2:0] idx);
        return SEG_W'(1) << idx;
    endfunction

endpackage

// File: rtl/hc595_shifter.sv
// Serialises one 16-bit word MSB-first into a 595 chain, then pulses the latch.
// Latency: 1 + 33*sclk_div cycles from start to done; start is ignored while a word is in flight.
// Backpressure: none; the caller must wait for done before issuing the next start.
module hc595_shifter
    import led7seg_pkg::*;
#(
    parameter int unsigned sclk_div = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              done,
    output logic              sclk,
    output logic              rclk,
    output logic              dio
);

    localparam int unsigned PH_W = (sclk_div > 1) ? $clog2(sclk_div) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(sclk_div - 1);

    scan_state_t       state;
    logic [PH_W-1:0]   phase;
    logic [3:0]        bitcnt;
    logic [WORD_W-1:0] word_q;
    logic              phase_end;

    assign phase_end = (phase == PH_LAST);

    // Combinational so the scheduler can enter HOLD on the very next cycle.
    assign done = (state == LATCH) && phase_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            phase  <= '0;
            bitcnt <= '0;
            word_q <= '0;
            sclk   <= 1'b0;
            rclk   <= 1'b0;
            dio    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (start) begin
                        state <= LOAD;
                    end
                end
                // The word is sampled here, after the scheduler has moved idx for this slot.
                LOAD: begin
                    word_q <= word;
                    dio    <= word[WORD_W-1];
                    bitcnt <= 4'd15;
                    phase  <= '0;
                    sclk   <= 1'b0;
                    state  <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        phase <= '0;
                        sclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                // dio only moves on the falling side so setup before each rise is sclk_div cycles.
                SHIFT_HI: begin
                    if (phase_end) begin
                        phase <= '0;
                        sclk  <= 1'b0;
                        if (bitcnt == 4'd0) begin
                            rclk  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bitcnt <= bitcnt - 4'd1;
                            dio    <= word_q[bitcnt - 4'd1];
                            state  <= SHIFT_LO;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        phase <= '0;
                        rclk  <= 1'b0;
                        dio   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Digit-scan scheduler: snapshots a frame, drives one 595 transaction per digit, holds each digit.
// Latency: slot = 1 + 33*sclk_div + digit_hold cycles; frame_done every num_digits slots.
// Backpressure: none; en only gates the start of the next slot, an active slot always completes.
module hc595_scan_ctrl
    import led7seg_pkg::*;
#(
    parameter int unsigned input_clk_freq = 100_000_000,
    parameter int unsigned sclk_div       = 4,
    parameter int unsigned digit_hold     = input_clk_freq / 1000,
    parameter int unsigned num_digits     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [MAX_DIGITS*SEG_W-1:0] seg_data,
    output logic                        sclk,
    output logic                        rclk,
    output logic                        dio,
    output logic [2:0]                  digit_idx,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int unsigned HC_W = (digit_hold > 1) ? $clog2(digit_hold) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(digit_hold - 1);
    localparam logic [2:0]      LAST_IDX  = 3'(num_digits - 1);

    scan_phase_t                           phase_st;
    logic [MAX_DIGITS-1:0][SEG_W-1:0]      frame_buf;
    logic [2:0]                            idx;
    logic [HC_W-1:0]                       hold_cnt;
    logic                                  hold_end;
    logic                                  last_digit;
    logic                                  start;
    logic                                  xfer_done;
    logic [WORD_W-1:0]                     word;

    always_comb begin
        hold_end   = (phase_st == SCAN_HOLD) && (hold_cnt == HOLD_LAST);
        last_digit = (idx == LAST_IDX);
        // A new slot starts from IDLE or straight out of HOLD, whenever en is still high.
        start      = en && ((phase_st == SCAN_IDLE) || hold_end);
        word       = {frame_buf[idx], digit_sel(idx)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_st   <= SCAN_IDLE;
            frame_buf  <= '0;
            idx        <= '0;
            hold_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (phase_st)
                SCAN_IDLE: begin
                    if (en) begin
                        frame_buf <= seg_data;
                        idx       <= '0;
                        phase_st  <= SCAN_XFER;
                    end
                end
                SCAN_XFER: begin
                    if (xfer_done) begin
                        hold_cnt <= '0;
                        phase_st <= SCAN_HOLD;
                    end
                end
                SCAN_HOLD: begin
                    if (hold_end) begin
                        if (last_digit) begin
                            frame_done <= 1'b1;
                            idx        <= '0;
                            if (en) begin
                                frame_buf <= seg_data;
                                phase_st  <= SCAN_XFER;
                            end else begin
                                phase_st  <= SCAN_IDLE;
                            end
                        end else if (!en) begin
                            idx      <= '0;
                            phase_st <= SCAN_IDLE;
                        end else begin
                            idx      <= idx + 3'd1;
                            phase_st <= SCAN_XFER;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    phase_st <= SCAN_IDLE;
                end
            endcase
        end
    end

    assign digit_idx = idx;
    assign busy      = (phase_st != SCAN_IDLE);

    hc595_shifter #(
        .sclk_div (sclk_div)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .word  (word),
        .done  (xfer_done),
        .sclk  (sclk),
        .rclk  (rclk),
        .dio   (dio)
    );

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Bench for hc595_scan_ctrl: pin-level monitors rebuild latched words and timing, compared to an arithmetic model.
module tb_hc595_scan_ctrl;

    localparam int A_DIV  = 4;
    localparam int A_HOLD = 10;
    localparam int A_ND   = 8;
    localparam int A_SLOT = 1 + 32 * A_DIV + A_DIV + A_HOLD;
    localparam int B_SLOT = 1 + 32 * 1 + 1 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, sclk_a, rclk_a, dio_a, busy_a, frame_done_a;
    logic [63:0] seg_a;
    logic [2:0]  digit_idx_a;
    logic        rst_b, en_b, sclk_b, rclk_b, dio_b, busy_b, frame_done_b;
    logic [63:0] seg_b;
    logic [2:0]  digit_idx_b;

    hc595_scan_ctrl #(
        .input_clk_freq (100_000_000),
        .sclk_div       (A_DIV),
        .digit_hold     (A_HOLD),
        .num_digits     (A_ND)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_a),
        .en         (en_a),
        .seg_data   (seg_a),
        .sclk       (sclk_a),
        .rclk       (rclk_a),
        .dio        (dio_a),
        .digit_idx  (digit_idx_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    hc595_scan_ctrl #(
        .input_clk_freq (100_000_000),
        .sclk_div       (1),
        .digit_hold     (1),
        .num_digits     (1)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_b),
        .en         (en_b),
        .seg_data   (seg_b),
        .sclk       (sclk_b),
        .rclk       (rclk_b),
        .dio        (dio_b),
        .digit_idx  (digit_idx_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What a 595 chain would hold: bits clocked on each sclk rise, captured at each rclk rise.
    logic        sclk_p = 0, rclk_p = 0, dio_p = 0, busy_p = 0;
    logic [15:0] sh_a = '0;
    int          nbits_a = 0, rw_a = 0, dio_viol = 0, busy_rise_a = 0, busy_fall_a = 0;
    logic [15:0] lat_w[$];
    int          lat_n[$], lat_i[$], lat_c[$], rw_q[$], fd_q[$];

    always @(negedge clk) begin
        sclk_p <= sclk_a;
        rclk_p <= rclk_a;
        dio_p  <= dio_a;
        busy_p <= busy_a;
        if (!rst_a) begin
            sh_a    <= '0;
            nbits_a <= 0;
            rw_a    <= 0;
        end else begin
            if (sclk_a && !sclk_p) begin
                sh_a    <= {sh_a[14:0], dio_a};
                nbits_a <= nbits_a + 1;
            end
            if (sclk_a && sclk_p && (dio_a !== dio_p)) dio_viol <= dio_viol + 1;
            if (rclk_a && !rclk_p) begin
                lat_w.push_back(sh_a);
                lat_n.push_back(nbits_a);
                lat_i.push_back(int'(digit_idx_a));
                lat_c.push_back(cyc);
                nbits_a <= 0;
                rw_a    <= 1;
            end else if (rclk_a) begin
                rw_a <= rw_a + 1;
            end
            if (!rclk_a && rclk_p) rw_q.push_back(rw_a);
            if (frame_done_a) fd_q.push_back(cyc);
            if (busy_a && !busy_p) busy_rise_a <= cyc;
            if (!busy_a && busy_p) busy_fall_a <= cyc;
        end
    end

    logic        sclkb_p = 0, rclkb_p = 0, busyb_p = 0;
    logic [15:0] sh_b = '0;
    int          idx_nz_b = 0, busy_rise_b = 0;
    logic [15:0] lat_b[$];
    int          fd_b[$];

    always @(negedge clk) begin
        sclkb_p <= sclk_b;
        rclkb_p <= rclk_b;
        busyb_p <= busy_b;
        if (rst_b) begin
            if (sclk_b && !sclkb_p) sh_b <= {sh_b[14:0], dio_b};
            if (rclk_b && !rclkb_p) lat_b.push_back(sh_b);
            if (frame_done_b) fd_b.push_back(cyc);
            if (digit_idx_b != 3'd0) idx_nz_b <= idx_nz_b + 1;
            if (busy_b && !busyb_p) busy_rise_b <= cyc;
        end
    end

    function automatic logic [15:0] exp_word(input logic [63:0] s, input int d);
        logic [7:0] sel;
        sel = 8'(1 << d);
        return {s[8*d +: 8], sel};
    endfunction

    logic [63:0] frm[3];
    logic [63:0] s4, s5;
    int          k, nd, cnt, n_exp;
    logic        prv;

    initial begin
        rst_a = 1'b0; en_a = 1'b0; seg_a = '0;
        rst_b = 1'b0; en_b = 1'b0; seg_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk_a, 1'b0);
        chk("rst_rclk", rclk_a, 1'b0);
        chk("rst_dio", dio_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_fdone", frame_done_a, 1'b0);
        chk("rst_idx", digit_idx_a, 3'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_en_busy", busy_a, 1'b0);

        // Three frames: data changes mid-frame must only show up one frame later.
        frm[0] = {$urandom, $urandom};
        frm[0][7:0]   = 8'hC0;
        frm[0][31:24] = 8'hF9;
        frm[1] = {$urandom, $urandom};
        frm[1][31:24] = 8'hA4;
        frm[2] = {$urandom, $urandom};
        seg_a = frm[0];
        en_a  = 1'b1;
        for (int i = 0; i < 3 * A_SLOT + 20 && digit_idx_a != 3'd2; i++) @(negedge clk);
        chk("wait_idx2", digit_idx_a, 3'd2);
        seg_a = frm[1];
        for (int i = 0; i < A_ND * A_SLOT && fd_q.size() < 1; i++) @(negedge clk);
        chk("wait_fd1", fd_q.size(), 1);
        for (int i = 0; i < 6 * A_SLOT + 20 && digit_idx_a != 3'd5; i++) @(negedge clk);
        chk("wait_f2_idx5", digit_idx_a, 3'd5);
        seg_a = frm[2];
        for (int i = 0; i < A_ND * A_SLOT && fd_q.size() < 2; i++) @(negedge clk);
        chk("wait_fd2", fd_q.size(), 2);
        for (int i = 0; i < 6 * A_SLOT + 20 && digit_idx_a != 3'd5; i++) @(negedge clk);
        chk("wait_f3_idx5", digit_idx_a, 3'd5);
        repeat (20) @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 2 * A_SLOT && busy_a; i++) @(negedge clk);
        chk("wait_idle", busy_a, 1'b0);
        repeat (2) @(negedge clk);
        chk("idle_sclk", sclk_a, 1'b0);
        chk("idle_rclk", rclk_a, 1'b0);
        chk("idle_dio", dio_a, 1'b0);
        chk("idle_idx", digit_idx_a, 3'd0);
        chk("dio_stable_hi", dio_viol, 0);

        n_exp = A_ND + A_ND + 6;
        chk("n_latches", lat_w.size(), n_exp);
        chk("first_word", lat_w[0], 16'hC001);
        chk("first_latch_time", lat_c[0] - busy_rise_a, 1 + 32 * A_DIV);
        chk("f1_digit3", lat_w[3][15:8], 8'hF9);
        chk("f2_digit3", lat_w[11][15:8], 8'hA4);
        chk("n_frame_done", fd_q.size(), 2);
        chk("fd1_time", fd_q[0] - busy_rise_a, A_ND * A_SLOT);
        chk("fd_period", fd_q[1] - fd_q[0], A_ND * A_SLOT);
        chk("busy_span", busy_fall_a - busy_rise_a, n_exp * A_SLOT);
        k = 0;
        for (int f = 0; f < 3; f++) begin
            nd = (f == 2) ? 6 : A_ND;
            for (int d = 0; d < nd; d++) begin
                if (k < lat_w.size() && k < rw_q.size()) begin
                    chk("word", lat_w[k], exp_word(frm[f], d));
                    chk("bits_per_word", lat_n[k], 16);
                    chk("idx_at_latch", lat_i[k], d);
                    chk("rclk_width", rw_q[k], A_DIV);
                    if (k > 0) begin
                        chk("slot_period", lat_c[k] - lat_c[k-1], A_SLOT);
                    end
                end
                k++;
            end
        end

        // Asynchronous reset while sclk is high with bitcnt=7 (ninth rising edge of digit 0).
        lat_w.delete(); lat_n.delete(); lat_i.delete(); lat_c.delete(); rw_q.delete();
        s4 = {$urandom, $urandom};
        seg_a = s4;
        en_a  = 1'b1;
        cnt = 0;
        prv = sclk_a;
        for (int i = 0; i < 400 && !(cnt == 9 && sclk_a); i++) begin
            @(negedge clk);
            if (sclk_a && !prv) cnt++;
            prv = sclk_a;
        end
        chk("reach_bit7", (cnt == 9 && sclk_a), 1'b1);
        rst_a = 1'b0;
        #1;
        chk("arst_sclk", sclk_a, 1'b0);
        chk("arst_rclk", rclk_a, 1'b0);
        chk("arst_dio", dio_a, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_idx", digit_idx_a, 3'd0);
        @(negedge clk);
        s5 = {$urandom, $urandom};
        seg_a = s5;
        rst_a = 1'b1;
        for (int i = 0; i < 2 * A_SLOT && lat_w.size() < 1; i++) @(negedge clk);
        chk("restart_latch", lat_w.size() >= 1, 1'b1);
        if (lat_w.size() >= 1) begin
            chk("restart_word", lat_w[0], exp_word(s5, 0));
            chk("restart_idx", lat_i[0], 0);
            chk("restart_bits", lat_n[0], 16);
        end
        en_a = 1'b0;
        for (int i = 0; i < 2 * A_SLOT && busy_a; i++) @(negedge clk);
        chk("restart_idle", busy_a, 1'b0);

        // Minimal configuration: one digit, sclk_div=1, digit_hold=1.
        seg_b = {$urandom, $urandom};
        en_b  = 1'b1;
        for (int i = 0; i < 5 * B_SLOT + 20 && fd_b.size() < 4; i++) @(negedge clk);
        en_b = 1'b0;
        chk("b_fd_count", fd_b.size() >= 4, 1'b1);
        if (fd_b.size() >= 4) begin
            chk("b_fd_first", fd_b[0] - busy_rise_b, B_SLOT);
            for (int i = 1; i < 4; i++) begin
                chk("b_fd_period", fd_b[i] - fd_b[i-1], B_SLOT);
            end
        end
        for (int i = 0; i < 2 * B_SLOT && busy_b; i++) @(negedge clk);
        chk("b_idle", busy_b, 1'b0);
        chk("b_idx_const", idx_nz_b, 0);
        chk("b_latch_count", lat_b.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < lat_b.size(); i++) begin
            chk("b_word", lat_b[i], exp_word(seg_b, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
